// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions, stall masks
// and the interrupt-entry FSM state encodings.
package pipe_ctrl_pkg;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Each mask freezes the requesting stage and everything upstream of it.
    localparam logic [5:0] MASK_IF  = 6'b000011;
    localparam logic [5:0] MASK_ID  = 6'b000111;
    localparam logic [5:0] MASK_EX  = 6'b001111;
    localparam logic [5:0] MASK_MEM = 6'b011111;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DRAIN = 2'b01;
    localparam logic [1:0] ST_SAVE  = 2'b10;
    localparam logic [1:0] ST_FLUSH = 2'b11;
endpackage

// File: rtl/pipe_ctrl_int_seq_fsm.sv
// Interrupt-entry sequencer: IDLE -> DRAIN -> SAVE -> FLUSH, holding the captured
// EPC, cause and trap vector for the duration of the sequence.
module int_seq_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  int_req_i,
    input  logic                  jump_req_i,
    input  logic                  stallreq_ex_i,
    input  logic                  stallreq_mem_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic [ADDR_WIDTH-1:0] int_cause_i,
    input  logic [ADDR_WIDTH-1:0] int_vector_i,
    input  logic [ADDR_WIDTH-1:0] id_inst_addr_i,
    output logic [1:0]            state_o,
    output logic [ADDR_WIDTH-1:0] vector_o,
    output logic                  epc_we_o,
    output logic [ADDR_WIDTH-1:0] epc_o,
    output logic [ADDR_WIDTH-1:0] cause_o,
    output logic                  flush_int_o
);
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] epc_capt;
    logic [ADDR_WIDTH-1:0] cause_capt;
    logic [ADDR_WIDTH-1:0] vector_capt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            epc_capt    <= '0;
            cause_capt  <= '0;
            vector_capt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A same-cycle jump is served first; the request is taken next cycle.
                    if (int_req_i && !jump_req_i) begin
                        state       <= ST_DRAIN;
                        cause_capt  <= int_cause_i;
                        vector_capt <= int_vector_i;
                    end
                end
                ST_DRAIN: begin
                    // A jump resolving while draining makes its target the resume point.
                    epc_capt <= jump_req_i ? jump_addr_i : id_inst_addr_i;
                    if (!stallreq_ex_i && !stallreq_mem_i)
                        state <= ST_SAVE;
                end
                ST_SAVE:  state <= ST_FLUSH;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode from state, so an async reset kills them immediately.
    assign state_o     = state;
    assign vector_o    = vector_capt;
    assign epc_we_o    = (state == ST_SAVE);
    assign epc_o       = (state == ST_SAVE) ? epc_capt : '0;
    assign cause_o     = (state == ST_SAVE) ? cause_capt : '0;
    assign flush_int_o = (state == ST_FLUSH);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, muxes jump/trap redirects and
// hosts the interrupt-entry sequencer.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int STALL_WIDTH = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   stallreq_if_i,
    input  logic                   stallreq_id_i,
    input  logic                   stallreq_ex_i,
    input  logic                   stallreq_mem_i,
    input  logic                   jump_req_i,
    input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
    input  logic                   int_req_i,
    input  logic [ADDR_WIDTH-1:0]  int_cause_i,
    input  logic [ADDR_WIDTH-1:0]  int_vector_i,
    input  logic [ADDR_WIDTH-1:0]  id_inst_addr_i,
    output logic [STALL_WIDTH-1:0] stall_o,
    output logic                   flush_jump_o,
    output logic                   flush_int_o,
    output logic                   redirect_o,
    output logic [ADDR_WIDTH-1:0]  redirect_addr_o,
    output logic                   epc_we_o,
    output logic [ADDR_WIDTH-1:0]  epc_o,
    output logic [ADDR_WIDTH-1:0]  cause_o,
    output logic                   int_busy_o
);
    logic [1:0]             state;
    logic [ADDR_WIDTH-1:0]  vector;
    logic [STALL_WIDTH-1:0] req_mask;

    int_seq_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_int_seq (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .int_req_i      (int_req_i),
        .jump_req_i     (jump_req_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .jump_addr_i    (jump_addr_i),
        .int_cause_i    (int_cause_i),
        .int_vector_i   (int_vector_i),
        .id_inst_addr_i (id_inst_addr_i),
        .state_o        (state),
        .vector_o       (vector),
        .epc_we_o       (epc_we_o),
        .epc_o          (epc_o),
        .cause_o        (cause_o),
        .flush_int_o    (flush_int_o)
    );

    always_comb begin
        if (stallreq_mem_i)     req_mask = MASK_MEM;
        else if (stallreq_ex_i) req_mask = MASK_EX;
        else if (stallreq_id_i) req_mask = MASK_ID;
        else if (stallreq_if_i) req_mask = MASK_IF;
        else                    req_mask = '0;
    end

    always_comb begin
        stall_o         = req_mask;
        flush_jump_o    = 1'b0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        case (state)
            ST_IDLE: begin
                // EX is frozen under a MEM stall, so the jump simply waits it out.
                flush_jump_o    = jump_req_i && !stallreq_mem_i;
                redirect_o      = jump_req_i && !stallreq_mem_i;
                redirect_addr_o = jump_addr_i;
            end
            ST_DRAIN: begin
                stall_o      = req_mask | MASK_ID;
                flush_jump_o = jump_req_i;
            end
            ST_SAVE:  stall_o = req_mask | MASK_ID;
            default: begin
                stall_o         = '0;
                redirect_o      = 1'b1;
                redirect_addr_o = vector;
            end
        endcase
        if (!rst_n_i) begin
            stall_o         = '0;
            flush_jump_o    = 1'b0;
            redirect_o      = 1'b0;
            redirect_addr_o = '0;
        end
    end

    assign int_busy_o = (state != ST_IDLE);
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, jump flush/hold, interrupt entry
// sequencing and reset during the sequence.
module tb_pipe_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        jump_req_i, int_req_i;
    logic [31:0] jump_addr_i, int_cause_i, int_vector_i, id_inst_addr_i;
    logic [5:0]  stall_o;
    logic        flush_jump_o, flush_int_o, redirect_o, epc_we_o, int_busy_o;
    logic [31:0] redirect_addr_o, epc_o, cause_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl #(.ADDR_WIDTH(32), .STALL_WIDTH(6)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .int_req_i       (int_req_i),
        .int_cause_i     (int_cause_i),
        .int_vector_i    (int_vector_i),
        .id_inst_addr_i  (id_inst_addr_i),
        .stall_o         (stall_o),
        .flush_jump_o    (flush_jump_o),
        .flush_int_o     (flush_int_o),
        .redirect_o      (redirect_o),
        .redirect_addr_o (redirect_addr_o),
        .epc_we_o        (epc_we_o),
        .epc_o           (epc_o),
        .cause_o         (cause_o),
        .int_busy_o      (int_busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " busy"},      {31'd0, int_busy_o},   32'd0);
        chk({tag, " epc_we"},    {31'd0, epc_we_o},     32'd0);
        chk({tag, " flush_int"}, {31'd0, flush_int_o},  32'd0);
        chk({tag, " flush_jmp"}, {31'd0, flush_jump_o}, 32'd0);
        chk({tag, " redirect"},  {31'd0, redirect_o},   32'd0);
    endtask

    initial begin
        bit found;
        rst_n_i = 1'b0;
        {stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i} = '0;
        jump_req_i = 1'b0; int_req_i = 1'b0;
        jump_addr_i = '0; int_cause_i = '0; int_vector_i = '0; id_inst_addr_i = '0;
        #12;
        chk("rst stall", {26'd0, stall_o}, 32'd0);
        chk_idle_outs("rst");
        chk("rst epc", epc_o, 32'd0);
        chk("rst redir_addr", redirect_addr_o, 32'd0);
        #6 rst_n_i = 1'b1;
        tick();

        // 1: load-use stall for two cycles
        stallreq_id_i = 1'b1;
        #1 chk("id stall c0", {26'd0, stall_o}, 32'h07);
        chk("id no flush c0", {31'd0, flush_jump_o}, 32'd0);
        tick();
        chk("id stall c1", {26'd0, stall_o}, 32'h07);
        stallreq_id_i = 1'b0;
        #1 chk("id stall off", {26'd0, stall_o}, 32'd0);
        chk("id no flush off", {31'd0, flush_jump_o}, 32'd0);
        tick();

        // 2: MEM beats IF
        stallreq_if_i = 1'b1; stallreq_mem_i = 1'b1;
        #1 chk("mem wins", {26'd0, stall_o}, 32'h1f);
        stallreq_mem_i = 1'b0;
        #1 chk("if only", {26'd0, stall_o}, 32'h03);
        stallreq_if_i = 1'b0;
        tick();

        // 3: jump, first held by a MEM stall, then served
        jump_req_i = 1'b1; jump_addr_i = 32'h200; stallreq_mem_i = 1'b1;
        #1 chk("jmp held flush", {31'd0, flush_jump_o}, 32'd0);
        chk("jmp held redir", {31'd0, redirect_o}, 32'd0);
        chk("jmp held stall", {26'd0, stall_o}, 32'h1f);
        tick();
        stallreq_mem_i = 1'b0;
        #1 chk("jmp flush", {31'd0, flush_jump_o}, 32'd1);
        chk("jmp redir", {31'd0, redirect_o}, 32'd1);
        chk("jmp addr", redirect_addr_o, 32'h200);
        tick();
        jump_req_i = 1'b0;
        #1 chk("jmp done", {31'd0, flush_jump_o}, 32'd0);

        // 4: interrupt entry with EX busy during the request cycle and two more
        int_req_i = 1'b1; stallreq_ex_i = 1'b1; id_inst_addr_i = 32'h100;
        int_vector_i = 32'h80; int_cause_i = 32'h8000_000b;
        #1 chk("int c0 busy", {31'd0, int_busy_o}, 32'd0);
        tick();
        int_req_i = 1'b0;
        #1 chk("drain1 busy", {31'd0, int_busy_o}, 32'd1);
        chk("drain1 stall", {26'd0, stall_o}, 32'h0f);
        chk("drain1 we", {31'd0, epc_we_o}, 32'd0);
        tick();
        chk("drain2 busy", {31'd0, int_busy_o}, 32'd1);
        chk("drain2 we", {31'd0, epc_we_o}, 32'd0);
        tick();
        stallreq_ex_i = 1'b0;
        #1 chk("drain3 busy", {31'd0, int_busy_o}, 32'd1);
        chk("drain3 stall", {26'd0, stall_o}, 32'h07);
        chk("drain3 we", {31'd0, epc_we_o}, 32'd0);
        tick();
        chk("save we", {31'd0, epc_we_o}, 32'd1);
        chk("save epc", epc_o, 32'h100);
        chk("save cause", cause_o, 32'h8000_000b);
        chk("save stall", {26'd0, stall_o}, 32'h07);
        tick();
        chk("flush we", {31'd0, epc_we_o}, 32'd0);
        chk("flush int", {31'd0, flush_int_o}, 32'd1);
        chk("flush redir", {31'd0, redirect_o}, 32'd1);
        chk("flush addr", redirect_addr_o, 32'h80);
        chk("flush stall", {26'd0, stall_o}, 32'd0);
        tick();
        chk_idle_outs("after int");

        // 5: jump and interrupt together; jump first, EPC becomes the jump target
        int_req_i = 1'b1; jump_req_i = 1'b1; jump_addr_i = 32'h300; id_inst_addr_i = 32'h2f0;
        #1 chk("jmp+int flush", {31'd0, flush_jump_o}, 32'd1);
        chk("jmp+int addr", redirect_addr_o, 32'h300);
        chk("jmp+int busy", {31'd0, int_busy_o}, 32'd0);
        tick();
        jump_req_i = 1'b0; id_inst_addr_i = 32'h300;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (epc_we_o) found = 1'b1;
        end
        chk("jmp+int save seen", {31'd0, found}, 32'd1);
        chk("jmp+int epc", epc_o, 32'h300);
        int_req_i = 1'b0;
        tick();
        chk("jmp+int flush int", {31'd0, flush_int_o}, 32'd1);
        tick();
        chk_idle_outs("after jmp+int");

        // 6: reset asserted during SAVE
        int_req_i = 1'b1;
        tick();
        int_req_i = 1'b0;
        tick();
        chk("pre-rst save we", {31'd0, epc_we_o}, 32'd1);
        #2 rst_n_i = 1'b0; stallreq_id_i = 1'b1;
        #1 chk("rst mid we", {31'd0, epc_we_o}, 32'd0);
        chk("rst mid busy", {31'd0, int_busy_o}, 32'd0);
        chk("rst mid epc", epc_o, 32'd0);
        chk("rst mid stall", {26'd0, stall_o}, 32'd0);
        stallreq_id_i = 1'b0;
        tick();
        #2 rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle_outs("post-rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
